// File: rtl/ysyx_24070017_ifu.sv
// ysyx_24070017_ifu: single-outstanding instruction fetch unit with redirect and wrong-path drop
// Optional misaligned-redirect trap enabled by YSYX_24070017_IFU_MISALIGN_CHECK_EN
module ysyx_24070017_ifu #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            req_valid,
    input  logic            req_ready,
    output logic [XLEN-1:0] req_addr,
    input  logic            rsp_valid,
    input  logic [XLEN-1:0] rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
    ,
    output logic            fetch_misaligned
`endif
);

`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT, S_FAULT} state_t;
`else
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_t;
`endif

    state_t          state_q, state_d, redir_st;
    logic [XLEN-1:0] pc_q, pc_d, inst_q, inst_d, redir_pc;
    logic            drop_q, drop_d, present;

    // redirect target PC and the state a redirect lands in
    always_comb begin
`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
        redir_pc = redirect_pc;
        redir_st = |redirect_pc[1:0] ? S_FAULT : S_REQ;
        present  = state_q == S_OUT || state_q == S_FAULT;
`else
        redir_pc = redirect_pc & ~XLEN'(3);
        redir_st = S_REQ;
        present  = state_q == S_OUT;
`endif
    end

    // next-state, PC, drop flag and instruction capture; redirect wins over everything
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        inst_d  = inst_q;
        unique case (state_q)
            S_REQ: begin
                if (req_ready) begin
                    state_d = S_WAIT;
                    drop_d  = drop_q | redirect_valid;
                end
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = (req_ready && redir_st == S_REQ) ? S_WAIT : redir_st;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    drop_d  = ~rsp_valid;
                    state_d = (rsp_valid || redir_st != S_REQ) ? redir_st : S_WAIT;
                end else if (rsp_valid) begin
                    drop_d  = 1'b0;
                    state_d = drop_q ? S_REQ : S_OUT;
                    inst_d  = drop_q ? inst_q : rsp_data;
                end
            end
            S_OUT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = redir_st;
                end else if (inst_ready) begin
                    pc_d    = pc_q + XLEN'(4);
                    state_d = S_REQ;
                end
            end
`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
            S_FAULT: begin
                if (redirect_valid) begin
                    pc_d    = redir_pc;
                    state_d = redir_st;
                end else if (rsp_valid) begin
                    drop_d  = 1'b0;
                end
            end
`endif
            default: state_d = S_REQ;
        endcase
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            drop_q  <= 1'b0;
            inst_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
            inst_q  <= inst_d;
        end
    end

    assign req_valid  = rst_n && state_q == S_REQ;
    assign req_addr   = pc_q;
    assign inst_valid = rst_n && present && !redirect_valid;
    assign inst       = (rst_n && state_q == S_OUT) ? inst_q : '0;
    assign inst_pc    = rst_n ? pc_q : RESET_PC;
`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
    assign fetch_misaligned = rst_n && state_q == S_FAULT;
`endif

endmodule

// File: tb/tb_ysyx_24070017_ifu.sv
// tb_ysyx_24070017_ifu: directed and random checks of the fetch unit against a PC-stream model
module tb_ysyx_24070017_ifu;
    localparam logic [31:0] RST = 32'h8000_0000;

    logic        clk = 0, rst_n = 0, redirect_valid = 0, req_ready = 0, rsp_valid = 0, inst_ready = 0;
    logic [31:0] redirect_pc = 0, rsp_data = 0;
    logic        req_valid, inst_valid;
    logic [31:0] req_addr, inst, inst_pc;
`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
    logic        fm;
`endif

    int checks = 0, errors = 0;
    bit          pend = 0, rr_rand = 0, mdl = 1;
    logic [31:0] pend_addr = 0, exp_pc = RST;
    int          cnt = 0, dly_lo = 0, dly_hi = 0, hs = 0, cyc = 0, last_hs = 0, gap = 0;
    bit          s_rv, s_iv, s_fire, s_hs;
    logic [31:0] s_ra, s_ipc, s_inst;
    logic [31:0] fa[$];

    ysyx_24070017_ifu dut (
        .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
        , .fetch_misaligned(fm)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // one clock cycle: drive inputs and memory, sample, check against the PC-stream model
    task automatic step(input bit r, input logic [31:0] rpc, input bit ir);
        @(negedge clk);
        redirect_valid = r;
        redirect_pc    = rpc;
        inst_ready     = ir;
        req_ready      = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        rsp_valid      = pend && cnt == 0;
        rsp_data       = rsp_valid ? mdata(pend_addr) : $urandom;
        #1;
        cyc++;
        s_rv = req_valid; s_iv = inst_valid; s_ra = req_addr; s_ipc = inst_pc; s_inst = inst;
        s_fire = req_valid && req_ready;
        s_hs   = inst_valid && ir;
        if (mdl) begin
            if (r) chk("kill_on_redirect", 32'(inst_valid), 0);
            if (s_fire) chk("one_outstanding", 32'(pend), 0);
            if (s_fire && !r) chk("req_addr", req_addr, exp_pc);
            if (inst_valid) begin
                chk("inst_pc", inst_pc, exp_pc);
                chk("inst", inst, mdata(exp_pc));
            end
        end
        if (s_hs) begin
            gap = cyc - last_hs;
            last_hs = cyc;
            hs++;
            exp_pc += 4;
        end
        if (r) exp_pc = rpc & ~32'd3;
        if (rsp_valid) pend = 0;
        else if (pend) cnt--;
        if (s_fire) begin
            pend = 1;
            pend_addr = req_addr;
            cnt = $urandom_range(dly_hi, dly_lo);
            fa.push_back(req_addr);
        end
    endtask

    initial begin
        int h0;
        logic [31:0] rpc;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(req_valid), 0);
        chk("rst_inst_valid", 32'(inst_valid), 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, RST);
`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
        chk("rst_misaligned", 32'(fm), 0);
`endif
        rst_n = 1;
        repeat (9) step(0, 0, 1);
        chk("first_addr0", fa[0], RST);
        chk("first_addr1", fa[1], RST + 4);
        chk("first_addr2", fa[2], RST + 8);
        chk("throughput_count", hs, 3);
        chk("throughput_gap", gap, 3);
        step(0, 0, 0);
        step(0, 0, 0);
        repeat (5) begin
            step(0, 0, 0);
            chk("stall_valid", 32'(s_iv), 1);
            chk("stall_no_req", 32'(s_rv), 0);
            chk("stall_pc", s_ipc, RST + 12);
            chk("stall_inst", s_inst, mdata(RST + 12));
        end
        dly_lo = 3; dly_hi = 3;
        step(0, 0, 1);
        step(0, 0, 0);
        chk("after_stall_fire", 32'(s_fire), 1);
        chk("after_stall_addr", s_ra, RST + 16);
        step(1, 32'h8000_0100, 0);
        for (int i = 0; i < 12 && !s_fire; i++) begin
            step(0, 0, 1);
            if (!s_fire) chk("drop_no_inst", 32'(s_iv), 0);
        end
        chk("redir_wait_fire", 32'(s_fire), 1);
        chk("redir_wait_addr", s_ra, 32'h8000_0100);
        dly_lo = 0; dly_hi = 0;
        for (int i = 0; i < 12 && !s_iv; i++) step(0, 0, 0);
        chk("reach_out", 32'(s_iv), 1);
        step(1, 32'h8000_0200, 1);
        chk("same_cycle_kill", 32'(s_iv), 0);
        step(0, 0, 1);
        chk("same_cycle_fire", 32'(s_fire), 1);
        chk("same_cycle_addr", s_ra, 32'h8000_0200);
        step(1, 32'hFFFF_FFFC, 1);
        s_hs = 0;
        for (int i = 0; i < 12 && !s_hs; i++) step(0, 0, 1);
        chk("wrap_pc", s_ipc, 32'hFFFF_FFFC);
        s_fire = 0;
        for (int i = 0; i < 12 && !s_fire; i++) step(0, 0, 1);
        chk("wrap_addr", s_ra, 32'h0000_0000);
        rr_rand = 1; dly_lo = 0; dly_hi = 3;
        h0 = hs;
        repeat (3000) begin
`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
            rpc = $urandom & ~32'd3;
`else
            rpc = $urandom;
`endif
            if ($urandom_range(0, 7) == 0) rpc = 32'hFFFF_FFFC;
            step($urandom_range(0, 15) == 0, rpc, $urandom_range(0, 3) != 0);
        end
        chk("random_progress", 32'(hs - h0 > 100), 1);
        rr_rand = 0; dly_lo = 0; dly_hi = 0;
`ifdef YSYX_24070017_IFU_MISALIGN_CHECK_EN
        mdl = 0;
        step(1, 32'h8000_0102, 0);
        step(0, 0, 0);
        chk("fault_no_req", 32'(s_rv), 0);
        chk("fault_valid", 32'(s_iv), 1);
        chk("fault_inst", s_inst, 0);
        chk("fault_pc", s_ipc, 32'h8000_0102);
        chk("fault_flag", 32'(fm), 1);
        step(0, 0, 1);
        step(0, 0, 0);
        chk("fault_stay_no_req", 32'(s_rv), 0);
        chk("fault_stay_flag", 32'(fm), 1);
`else
        step(1, 32'h8000_0102, 0);
        s_fire = 0;
        for (int i = 0; i < 12 && !s_fire; i++) step(0, 0, 1);
        chk("misalign_fire", 32'(s_fire), 1);
        chk("misalign_addr", s_ra, 32'h8000_0100);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
